// File: rtl/digital_mem_bridge_pkg.sv
// rtl/digital_mem_bridge_pkg.sv - shared constants and state encoding for the Digital memory bridge
package digital_mem_bridge_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_ADDR_W = 32;

  typedef enum logic [1:0] {
    BRIDGE_IDLE     = 2'd0,
    BRIDGE_ISSUE    = 2'd1,
    BRIDGE_WAIT_ACK = 2'd2,
    BRIDGE_RESP     = 2'd3
  } bridge_state_e;

endpackage

// File: rtl/digital_mem_lane_align.sv
// rtl/digital_mem_lane_align.sv - byte-lane enables, write placement and read extraction for one or two beats
module digital_mem_lane_align
  import digital_mem_bridge_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int NBYTES = XLEN / 8,
  parameter int OW     = $clog2(NBYTES)
) (
  input  logic [OW-1:0]     off,
  input  logic [OW:0]       bytes,
  input  logic              beat,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata0,
  input  logic [XLEN-1:0]   rdata1,
  output logic [NBYTES-1:0] byte_en,
  output logic [XLEN-1:0]   wdata_lane,
  output logic [XLEN-1:0]   rdata_out,
  output logic              split
);

  logic [NBYTES-1:0]   lane_mask;
  logic [XLEN-1:0]     data_mask;
  logic [2*NBYTES-1:0] be_wide;
  logic [2*XLEN-1:0]   wd_wide;
  logic [2*XLEN-1:0]   rd_wide;

  // Low 'bytes' lanes of the access, and the same mask expanded to bits
  always_comb begin
    lane_mask = '0;
    data_mask = '0;
    for (int i = 0; i < NBYTES; i++) begin
      lane_mask[i]       = ((OW+1)'(i) < bytes);
      data_mask[i*8 +: 8] = {8{lane_mask[i]}};
    end
  end

  // The access viewed across two adjacent words: beat 0 is the low word, beat 1 the high word
  assign be_wide = {{NBYTES{1'b0}}, lane_mask} << off;
  assign wd_wide = {{XLEN{1'b0}}, wdata & data_mask} << {off, 3'b000};
  assign rd_wide = {rdata1, rdata0} >> {off, 3'b000};

  assign byte_en    = beat ? be_wide[2*NBYTES-1:NBYTES] : be_wide[NBYTES-1:0];
  assign wdata_lane = beat ? wd_wide[2*XLEN-1:XLEN] : wd_wide[XLEN-1:0];
  assign rdata_out  = rd_wide[XLEN-1:0] & data_mask;
  assign split      = (({1'b0, off} + bytes) > (OW+1)'(NBYTES));

endmodule

// File: rtl/digital_mem_bridge.sv
// rtl/digital_mem_bridge.sv - mem_io request bus to Digital RAM port bridge with split, timeout and abort
module digital_mem_bridge
  import digital_mem_bridge_pkg::*;
#(
  parameter int XLEN             = DEF_XLEN,
  parameter int ADDR_W           = DEF_ADDR_W,
  parameter int NBYTES           = XLEN / 8,
  parameter int SIZE_W           = $clog2(NBYTES),
  parameter int TIMEOUT_CYC      = 255,
  parameter int SPLIT_MISALIGNED = 1
) (
  input  logic              ramclk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_io_addr,
  input  logic              mem_io_read,
  input  logic              mem_io_write,
  input  logic [XLEN-1:0]   mem_io_wdata,
  input  logic [SIZE_W-1:0] io_byte_size,
  output logic [XLEN-1:0]   mem_io_rdata,
  output logic              mem_io_ready,
  output logic              mem_io_err,
  output logic [ADDR_W-1:0] digital_mem_addr,
  output logic              digital_mem_read_en,
  output logic              digital_mem_write_en,
  output logic [NBYTES-1:0] digital_mem_byte_en,
  output logic [XLEN-1:0]   digital_mem_wdata,
  input  logic [XLEN-1:0]   digital_mem_data,
  input  logic              digital_mem_ready
);

  localparam int OW = SIZE_W;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  bridge_state_e     state;
  logic [ADDR_W-1:0] base_q;
  logic [OW-1:0]     off_q;
  logic [OW:0]       bytes_q;
  logic [XLEN-1:0]   wdata_q;
  logic              wr_q;
  logic              beat_q;
  logic              split_q;
  logic [XLEN-1:0]   rd0_q;
  logic [TW-1:0]     tcnt;

  logic              req;
  logic [OW-1:0]     off_in;
  logic [OW:0]       bytes_in;
  logic              misaligned_in;
  logic [NBYTES-1:0] al_byte_en;
  logic [XLEN-1:0]   al_wdata;
  logic [XLEN-1:0]   al_rdata;
  logic              al_split;
  logic [XLEN-1:0]   al_rdata0;
  logic [XLEN-1:0]   al_rdata1;

  assign req           = mem_io_read | mem_io_write;
  assign off_in        = mem_io_addr[OW-1:0];
  assign bytes_in      = (io_byte_size == '0) ? (OW+1)'(NBYTES) : {1'b0, io_byte_size};
  assign misaligned_in = (({1'b0, off_in} + bytes_in) > (OW+1)'(NBYTES));

  // While beat 1 is acknowledged its data arrives live; beat 0 data is already held in rd0_q
  assign al_rdata0 = beat_q ? rd0_q : digital_mem_data;
  assign al_rdata1 = beat_q ? digital_mem_data : '0;

  digital_mem_lane_align #(
    .XLEN   (XLEN),
    .NBYTES (NBYTES),
    .OW     (OW)
  ) u_align (
    .off        (off_q),
    .bytes      (bytes_q),
    .beat       (beat_q),
    .wdata      (wdata_q),
    .rdata0     (al_rdata0),
    .rdata1     (al_rdata1),
    .byte_en    (al_byte_en),
    .wdata_lane (al_wdata),
    .rdata_out  (al_rdata),
    .split      (al_split)
  );

  // Bridge FSM: latch request, issue one or two beats, wait for ack or timeout, hold response
  always_ff @(posedge ramclk or negedge rst) begin
    if (!rst) begin
      state                <= BRIDGE_IDLE;
      base_q               <= '0;
      off_q                <= '0;
      bytes_q              <= '0;
      wdata_q              <= '0;
      wr_q                 <= 1'b0;
      beat_q               <= 1'b0;
      split_q              <= 1'b0;
      rd0_q                <= '0;
      tcnt                 <= '0;
      mem_io_rdata         <= '0;
      mem_io_ready         <= 1'b0;
      mem_io_err           <= 1'b0;
      digital_mem_addr     <= '0;
      digital_mem_read_en  <= 1'b0;
      digital_mem_write_en <= 1'b0;
      digital_mem_byte_en  <= '0;
      digital_mem_wdata    <= '0;
    end else begin
      case (state)
        BRIDGE_IDLE: begin
          if (req) begin
            base_q  <= {mem_io_addr[ADDR_W-1:OW], {OW{1'b0}}};
            off_q   <= off_in;
            bytes_q <= bytes_in;
            wdata_q <= mem_io_write ? mem_io_wdata : '0;
            wr_q    <= mem_io_write;
            beat_q  <= 1'b0;
            split_q <= misaligned_in;
            if ((mem_io_read && mem_io_write) || (misaligned_in && SPLIT_MISALIGNED == 0)) begin
              mem_io_ready <= 1'b1;
              mem_io_err   <= 1'b1;
              mem_io_rdata <= '0;
              state        <= BRIDGE_RESP;
            end else begin
              state <= BRIDGE_ISSUE;
            end
          end
        end
        BRIDGE_ISSUE: begin
          if (!req) begin
            state <= BRIDGE_IDLE;
          end else begin
            digital_mem_addr     <= beat_q ? base_q + ADDR_W'(NBYTES) : base_q;
            digital_mem_byte_en  <= al_byte_en;
            digital_mem_wdata    <= al_wdata;
            digital_mem_read_en  <= !wr_q;
            digital_mem_write_en <= wr_q;
            tcnt                 <= '0;
            state                <= BRIDGE_WAIT_ACK;
          end
        end
        BRIDGE_WAIT_ACK: begin
          if (!req) begin
            digital_mem_read_en  <= 1'b0;
            digital_mem_write_en <= 1'b0;
            state                <= BRIDGE_IDLE;
          end else if (digital_mem_ready) begin
            digital_mem_read_en  <= 1'b0;
            digital_mem_write_en <= 1'b0;
            if (!beat_q) rd0_q <= digital_mem_data;
            if (!beat_q && split_q) begin
              beat_q <= 1'b1;
              state  <= BRIDGE_ISSUE;
            end else begin
              mem_io_ready <= 1'b1;
              mem_io_err   <= 1'b0;
              mem_io_rdata <= wr_q ? '0 : al_rdata;
              state        <= BRIDGE_RESP;
            end
          end else if (TIMEOUT_CYC != 0 && tcnt == TLAST) begin
            digital_mem_read_en  <= 1'b0;
            digital_mem_write_en <= 1'b0;
            mem_io_ready         <= 1'b1;
            mem_io_err           <= 1'b1;
            mem_io_rdata         <= '0;
            state                <= BRIDGE_RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        BRIDGE_RESP: begin
          if (!req) begin
            mem_io_ready <= 1'b0;
            mem_io_err   <= 1'b0;
            state        <= BRIDGE_IDLE;
          end
        end
        default: state <= BRIDGE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digital_mem_bridge.sv
// tb/tb_digital_mem_bridge.sv - directed vector bench for digital_mem_bridge
module tb_digital_mem_bridge;

  logic        ramclk = 1'b0;
  logic        rst    = 1'b0;
  logic [31:0] mem_io_addr  = '0;
  logic        mem_io_read  = 1'b0;
  logic        mem_io_write = 1'b0;
  logic [31:0] mem_io_wdata = '0;
  logic [1:0]  io_byte_size = '0;
  logic [31:0] mem_io_rdata;
  logic        mem_io_ready;
  logic        mem_io_err;
  logic [31:0] digital_mem_addr;
  logic        digital_mem_read_en;
  logic        digital_mem_write_en;
  logic [3:0]  digital_mem_byte_en;
  logic [31:0] digital_mem_wdata;
  logic [31:0] digital_mem_data  = '0;
  logic        digital_mem_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] d0;
    logic [31:0] d1;
    int          nb;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [3:0]  be0;
    logic [3:0]  be1;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [8];

  digital_mem_bridge #(.TIMEOUT_CYC(8)) dut (
    .ramclk               (ramclk),
    .rst                  (rst),
    .mem_io_addr          (mem_io_addr),
    .mem_io_read          (mem_io_read),
    .mem_io_write         (mem_io_write),
    .mem_io_wdata         (mem_io_wdata),
    .io_byte_size         (io_byte_size),
    .mem_io_rdata         (mem_io_rdata),
    .mem_io_ready         (mem_io_ready),
    .mem_io_err           (mem_io_err),
    .digital_mem_addr     (digital_mem_addr),
    .digital_mem_read_en  (digital_mem_read_en),
    .digital_mem_write_en (digital_mem_write_en),
    .digital_mem_byte_en  (digital_mem_byte_en),
    .digital_mem_wdata    (digital_mem_wdata),
    .digital_mem_data     (digital_mem_data),
    .digital_mem_ready    (digital_mem_ready)
  );

  always #5 ramclk = ~ramclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_en(input string name);
    int n = 0;
    while (!(digital_mem_read_en || digital_mem_write_en) && n < 20) begin
      @(negedge ramclk);
      n++;
    end
    chk(name, 32'(digital_mem_read_en | digital_mem_write_en), 32'd1);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!mem_io_ready && n < 20) begin
      @(negedge ramclk);
      n++;
    end
    chk(name, 32'(mem_io_ready), 32'd1);
  endtask

  task automatic run_vec(input int idx, input int dly);
    vec_t v = vecs[idx];
    mem_io_addr  = v.addr;
    mem_io_read  = !v.wr;
    mem_io_write = v.wr;
    io_byte_size = v.size;
    mem_io_wdata = v.wdata;
    for (int b = 0; b < v.nb; b++) begin
      wait_en($sformatf("v%0d_b%0d_en", idx, b));
      chk($sformatf("v%0d_b%0d_dir", idx, b), 32'({digital_mem_read_en, digital_mem_write_en}),
          v.wr ? 32'd1 : 32'd2);
      chk($sformatf("v%0d_b%0d_addr", idx, b), digital_mem_addr, b == 0 ? v.a0 : v.a1);
      chk($sformatf("v%0d_b%0d_be", idx, b), 32'(digital_mem_byte_en), 32'(b == 0 ? v.be0 : v.be1));
      chk($sformatf("v%0d_b%0d_wdata", idx, b), digital_mem_wdata, b == 0 ? v.w0 : v.w1);
      repeat (dly) @(negedge ramclk);
      digital_mem_ready = 1'b1;
      digital_mem_data  = (b == 0) ? v.d0 : v.d1;
      @(negedge ramclk);
      digital_mem_ready = 1'b0;
      chk($sformatf("v%0d_b%0d_en_drop", idx, b), 32'(digital_mem_read_en | digital_mem_write_en), 32'd0);
    end
    wait_ready($sformatf("v%0d_ready", idx));
    chk($sformatf("v%0d_rdata", idx), mem_io_rdata, v.rdata);
    chk($sformatf("v%0d_err", idx), 32'(mem_io_err), 32'd0);
    @(negedge ramclk);
    chk($sformatf("v%0d_ready_held", idx), 32'(mem_io_ready), 32'd1);
    mem_io_read  = 1'b0;
    mem_io_write = 1'b0;
    @(negedge ramclk);
    chk($sformatf("v%0d_ready_clr", idx), 32'(mem_io_ready), 32'd0);
  endtask

  initial begin
    int  k;
    int  cnt;
    bit  seen;

    //          addr       wr    sz    wdata         d0            d1            nb a0         a1         be0   be1   w0            w1            rdata
    vecs[0] = '{32'h100, 1'b1, 2'd0, 32'hDEADBEEF, 32'h0,        32'h0,        1, 32'h100, 32'h0,   4'hF, 4'h0, 32'hDEADBEEF, 32'h0,        32'h0};
    vecs[1] = '{32'h203, 1'b0, 2'd1, 32'h0,        32'hAABBCCDD, 32'h0,        1, 32'h200, 32'h0,   4'h8, 4'h0, 32'h0,        32'h0,        32'hAA};
    vecs[2] = '{32'h107, 1'b1, 2'd2, 32'h1234,     32'h0,        32'h0,        2, 32'h104, 32'h108, 4'h8, 4'h1, 32'h34000000, 32'h12,       32'h0};
    vecs[3] = '{32'h0FE, 1'b0, 2'd0, 32'h0,        32'h44332211, 32'h88776655, 2, 32'h0FC, 32'h100, 4'hC, 4'h3, 32'h0,        32'h0,        32'h66554433};
    vecs[4] = '{32'h302, 1'b0, 2'd2, 32'hFFFFFFFF, 32'hCAFEBABE, 32'h0,        1, 32'h300, 32'h0,   4'hC, 4'h0, 32'h0,        32'h0,        32'hCAFE};
    vecs[5] = '{32'h401, 1'b1, 2'd3, 32'hFF123456, 32'h0,        32'h0,        1, 32'h400, 32'h0,   4'hE, 4'h0, 32'h12345600, 32'h0,        32'h0};
    vecs[6] = '{32'h503, 1'b0, 2'd3, 32'h0,        32'h11223344, 32'h55667788, 2, 32'h500, 32'h504, 4'h8, 4'h3, 32'h0,        32'h0,        32'h778811};
    vecs[7] = '{32'h010, 1'b1, 2'd1, 32'hAB,       32'h0,        32'h0,        1, 32'h010, 32'h0,   4'h1, 4'h0, 32'hAB,       32'h0,        32'h0};

    // Reset state
    #3;
    chk("rst_ready", 32'(mem_io_ready), 32'd0);
    chk("rst_err", 32'(mem_io_err), 32'd0);
    chk("rst_en", 32'({digital_mem_read_en, digital_mem_write_en}), 32'd0);
    chk("rst_be", 32'(digital_mem_byte_en), 32'd0);
    chk("rst_addr", digital_mem_addr, 32'd0);
    @(negedge ramclk);
    rst = 1'b1;
    @(negedge ramclk);

    // Table-driven accesses with varying ack delay
    for (int i = 0; i < 8; i++) run_vec(i, (i == 0) ? 2 : i % 3);

    // Latency with zero-wait memory: aligned 3 cycles, split 5 cycles
    digital_mem_ready = 1'b1;
    digital_mem_data  = 32'h12345678;
    mem_io_addr = 32'h20; io_byte_size = 2'd0; mem_io_read = 1'b1;
    k = 0;
    while (!mem_io_ready && k < 20) begin @(negedge ramclk); k++; end
    chk("lat_aligned", 32'(k), 32'd3);
    chk("lat_aligned_rdata", mem_io_rdata, 32'h12345678);
    mem_io_read = 1'b0;
    @(negedge ramclk);
    mem_io_addr = 32'h0FE; mem_io_read = 1'b1;
    k = 0;
    while (!mem_io_ready && k < 20) begin @(negedge ramclk); k++; end
    chk("lat_split", 32'(k), 32'd5);
    chk("lat_split_rdata", mem_io_rdata, 32'h56781234);
    mem_io_read = 1'b0;
    digital_mem_ready = 1'b0;
    @(negedge ramclk);

    // Withdrawal in WAIT_ACK: enable drops, ready never asserts
    mem_io_addr = 32'h700; mem_io_read = 1'b1;
    wait_en("wd_en");
    @(negedge ramclk);
    mem_io_read = 1'b0;
    @(negedge ramclk);
    chk("wd_en_drop", 32'(digital_mem_read_en), 32'd0);
    seen = 1'b0;
    repeat (5) begin
      if (mem_io_ready) seen = 1'b1;
      @(negedge ramclk);
    end
    chk("wd_no_ready", 32'(seen), 32'd0);

    // Read and write together: error, no external access
    mem_io_addr = 32'h800; mem_io_read = 1'b1; mem_io_write = 1'b1;
    seen = 1'b0; k = 0;
    while (!mem_io_ready && k < 10) begin
      @(negedge ramclk);
      if (digital_mem_read_en || digital_mem_write_en) seen = 1'b1;
      k++;
    end
    chk("ill_ready", 32'(mem_io_ready), 32'd1);
    chk("ill_err", 32'(mem_io_err), 32'd1);
    chk("ill_no_en", 32'(seen), 32'd0);
    mem_io_read = 1'b0; mem_io_write = 1'b0;
    @(negedge ramclk);
    chk("ill_clr", 32'({mem_io_ready, mem_io_err}), 32'd0);

    // Timeout: enable high for 8 cycles then error response
    mem_io_addr = 32'h600; mem_io_read = 1'b1; io_byte_size = 2'd0;
    wait_en("to_en");
    cnt = 0;
    while (digital_mem_read_en && cnt < 50) begin
      cnt++;
      @(negedge ramclk);
    end
    chk("to_cycles", 32'(cnt), 32'd8);
    chk("to_ready", 32'(mem_io_ready), 32'd1);
    chk("to_err", 32'(mem_io_err), 32'd1);
    chk("to_rdata", mem_io_rdata, 32'd0);
    mem_io_read = 1'b0;
    @(negedge ramclk);

    // Leave nonzero rdata behind, then reset during beat 1 of a split read
    run_vec(1, 0);
    mem_io_addr = 32'h0FE; io_byte_size = 2'd0; mem_io_read = 1'b1;
    wait_en("rs_b0_en");
    digital_mem_ready = 1'b1; digital_mem_data = 32'h11111111;
    @(negedge ramclk);
    digital_mem_ready = 1'b0;
    wait_en("rs_b1_en");
    chk("rs_b1_addr", digital_mem_addr, 32'h100);
    #2 rst = 1'b0;
    #1;
    chk("rs_en", 32'({digital_mem_read_en, digital_mem_write_en}), 32'd0);
    chk("rs_ready_err", 32'({mem_io_ready, mem_io_err}), 32'd0);
    chk("rs_rdata", mem_io_rdata, 32'd0);
    chk("rs_be", 32'(digital_mem_byte_en), 32'd0);
    chk("rs_addr", digital_mem_addr, 32'd0);
    mem_io_read = 1'b0;
    @(negedge ramclk);
    rst = 1'b1;
    @(negedge ramclk);
    run_vec(4, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
